// File: rtl/mem_stage_lsu.sv
// Memory stage with a variable-latency data-SRAM handshake, load extraction and a forwarding bus.
// Optional misaligned-access detection is enabled by defining MEM_ALIGN_CHK_EN.
//
// state | meaning
// IDLE  | no outstanding load in the stage
// WAIT  | load latched, SRAM data not yet returned
// HOLD  | data returned while writeback stalled, kept in r_rdata_buf
module mem_stage_lsu #(
  parameter  int DATA_WD    = 32,
  parameter  int PC_WD      = 32,
  parameter  int RA_WD      = 5,
  localparam int ES_BUS_WD  = 5 + RA_WD + DATA_WD + PC_WD,
`ifdef MEM_ALIGN_CHK_EN
  localparam int MS_BUS_WD  = 2 + RA_WD + DATA_WD + PC_WD,
`else
  localparam int MS_BUS_WD  = 1 + RA_WD + DATA_WD + PC_WD,
`endif
  localparam int FWD_BUS_WD = 2 + RA_WD + DATA_WD
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ws_allowin,
  output logic                  o_ms_allowin,
  input  logic                  i_es_to_ms_valid,
  input  logic [ES_BUS_WD-1:0]  i_es_to_ms_bus,
  output logic                  o_ms_to_ws_valid,
  output logic [MS_BUS_WD-1:0]  o_ms_to_ws_bus,
  output logic [FWD_BUS_WD-1:0] o_mem_fwd_bus,
  input  logic                  i_data_sram_data_ok,
  input  logic [DATA_WD-1:0]    i_data_sram_rdata
);

  localparam int OFF_WD = $clog2(DATA_WD / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_ms_valid;
  logic                   r_buf_valid;
  logic [ES_BUS_WD-1:0]   r_es_bus;
  logic [DATA_WD-1:0]     r_rdata_buf;

  logic [2:0]             w_ld_op;
  logic                   w_res_from_mem;
  logic                   w_gr_we;
  logic [RA_WD-1:0]       w_dest;
  logic [DATA_WD-1:0]     w_alu_result;
  logic [PC_WD-1:0]       w_pc;
  logic [OFF_WD-1:0]      w_off;

  logic                   w_es_res_from_mem;
  logic                   w_ale;
  logic                   w_es_ale;
  logic                   w_load;
  logic                   w_load_in;
  logic                   w_data_ok_live;
  logic                   w_ms_ready_go;
  logic                   w_ms_allowin;
  logic                   w_capture;
  logic                   w_gr_we_eff;

  logic [DATA_WD-1:0]     w_raw;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [DATA_WD-1:0]     w_ext;
  logic [DATA_WD-1:0]     w_final_result;

  assign w_ld_op        = r_es_bus[ES_BUS_WD-1 -: 3];
  assign w_res_from_mem = r_es_bus[ES_BUS_WD-4];
  assign w_gr_we        = r_es_bus[ES_BUS_WD-5];
  assign w_dest         = r_es_bus[PC_WD+DATA_WD +: RA_WD];
  assign w_alu_result   = r_es_bus[PC_WD +: DATA_WD];
  assign w_pc           = r_es_bus[PC_WD-1:0];
  assign w_off          = w_alu_result[OFF_WD-1:0];

  assign w_es_res_from_mem = i_es_to_ms_bus[ES_BUS_WD-4];

`ifdef MEM_ALIGN_CHK_EN
  function automatic logic f_misalign(input logic [2:0] op, input logic [OFF_WD-1:0] off);
    case (op)
      3'b001, 3'b010: return 1'b0;
      3'b011, 3'b100: return off[0];
      default:        return |off;
    endcase
  endfunction

  assign w_ale    = w_res_from_mem && f_misalign(w_ld_op, w_off);
  assign w_es_ale = w_es_res_from_mem &&
                    f_misalign(i_es_to_ms_bus[ES_BUS_WD-1 -: 3], i_es_to_ms_bus[PC_WD +: OFF_WD]);
`else
  assign w_ale    = 1'b0;
  assign w_es_ale = 1'b0;
`endif

  // A misaligned access never issued a request, so it is not treated as a load.
  assign w_load      = r_ms_valid && w_res_from_mem && !w_ale;
  assign w_gr_we_eff = w_gr_we && !w_ale;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_capture) begin
      w_state_nxt = S_HOLD;
    end else if (w_ms_allowin) begin
      w_state_nxt = w_load_in ? S_WAIT : S_IDLE;
    end
  end

  // Handshake outputs derived from state
  always_comb begin
    w_data_ok_live = i_data_sram_data_ok && (r_state == S_WAIT);
    w_ms_ready_go  = !w_load || w_data_ok_live || r_buf_valid;
    w_ms_allowin   = !r_ms_valid || (w_ms_ready_go && i_ws_allowin);
    w_capture      = w_data_ok_live && !i_ws_allowin;
    w_load_in      = i_es_to_ms_valid && w_ms_allowin && w_es_res_from_mem && !w_es_ale;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ms_valid  <= 1'b0;
      r_buf_valid <= 1'b0;
    end else begin
      if (w_ms_allowin) begin
        r_ms_valid <= i_es_to_ms_valid;
      end
      if (w_capture) begin
        r_buf_valid <= 1'b1;
      end else if (w_ms_allowin) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_es_to_ms_valid && w_ms_allowin) begin
      r_es_bus <= i_es_to_ms_bus;
    end
    if (w_capture) begin
      r_rdata_buf <= i_data_sram_rdata;
    end
  end

  assign w_raw  = r_buf_valid ? r_rdata_buf : i_data_sram_rdata;
  assign w_byte = 8'(w_raw >> {w_off, 3'b000});
  assign w_half = 16'(w_raw >> {w_off[OFF_WD-1:1], 4'b0000});

  always_comb begin
    w_ext = w_raw;
    case (w_ld_op)
      3'b001:  w_ext = {{(DATA_WD-8){w_byte[7]}}, w_byte};
      3'b010:  w_ext = {{(DATA_WD-8){1'b0}}, w_byte};
      3'b011:  w_ext = {{(DATA_WD-16){w_half[15]}}, w_half};
      3'b100:  w_ext = {{(DATA_WD-16){1'b0}}, w_half};
      default: w_ext = w_raw;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_ext : w_alu_result;

  assign o_ms_allowin     = w_ms_allowin;
  assign o_ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
`ifdef MEM_ALIGN_CHK_EN
  assign o_ms_to_ws_bus   = {w_ale, w_gr_we_eff, w_dest, w_final_result, w_pc};
`else
  assign o_ms_to_ws_bus   = {w_gr_we_eff, w_dest, w_final_result, w_pc};
`endif
  assign o_mem_fwd_bus    = {r_ms_valid && w_gr_we_eff, w_ms_ready_go, w_dest, w_final_result};

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios with literal results, then randomized traffic
// compared each cycle against a transaction-level model of the stage.
module tb_mem_stage_lsu;
  localparam int DW  = 32;
  localparam int PW  = 32;
  localparam int RW  = 5;
  localparam int ESW = 5 + RW + DW + PW;
`ifdef MEM_ALIGN_CHK_EN
  localparam int MSW = 2 + RW + DW + PW;
  localparam bit ALN = 1'b1;
`else
  localparam int MSW = 1 + RW + DW + PW;
  localparam bit ALN = 1'b0;
`endif
  localparam int FWW = 2 + RW + DW;

  logic           clk = 1'b0;
  logic           reset;
  logic           ws_allowin;
  logic           ms_allowin;
  logic           es_valid;
  logic [ESW-1:0] es_bus;
  logic           ms_valid_o;
  logic [MSW-1:0] ms_bus;
  logic [FWW-1:0] fwd_bus;
  logic           data_ok;
  logic [DW-1:0]  rdata;

  always #5 clk = ~clk;

  mem_stage_lsu #(.DATA_WD(DW), .PC_WD(PW), .RA_WD(RW)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_ws_allowin       (ws_allowin),
    .o_ms_allowin       (ms_allowin),
    .i_es_to_ms_valid   (es_valid),
    .i_es_to_ms_bus     (es_bus),
    .o_ms_to_ws_valid   (ms_valid_o),
    .o_ms_to_ws_bus     (ms_bus),
    .o_mem_fwd_bus      (fwd_bus),
    .i_data_sram_data_ok(data_ok),
    .i_data_sram_rdata  (rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction model: the instruction held in the stage and any data already received for it.
  bit            m_valid = 1'b0;
  bit            m_have  = 1'b0;
  logic [2:0]    m_op;
  bit            m_res, m_we;
  logic [RW-1:0] m_dest;
  logic [DW-1:0] m_alu, m_pc, m_data;

  bit            e_ready, e_valid, e_allowin, e_ale, e_live;
  logic [DW-1:0] e_result;

  function automatic logic [ESW-1:0] mk(input int op, input bit res, input bit we, input int dest,
                                        input logic [DW-1:0] alu, input logic [PW-1:0] pc);
    return {3'(op), res, we, RW'(dest), alu, pc};
  endfunction

  function automatic logic [DW-1:0] extract(input logic [2:0] op, input logic [DW-1:0] alu,
                                            input logic [DW-1:0] raw);
    int off, b, h;
    off = int'(alu % (DW / 8));
    b   = int'((raw >> (8 * off)) & 32'hFF);
    h   = int'((raw >> (16 * (off / 2))) & 32'hFFFF);
    case (op)
      3'd1:    return (b >= 128) ? DW'(b - 256) : DW'(b);
      3'd2:    return DW'(b);
      3'd3:    return (h >= 32768) ? DW'(h - 65536) : DW'(h);
      3'd4:    return DW'(h);
      default: return raw;
    endcase
  endfunction

  function automatic bit ale_of(input logic [2:0] op, input bit res, input logic [DW-1:0] alu);
    int off;
    bit mis;
    off = int'(alu % (DW / 8));
    if (op == 3'd1 || op == 3'd2)      mis = 1'b0;
    else if (op == 3'd3 || op == 3'd4) mis = (off % 2) != 0;
    else                               mis = off != 0;
    return ALN && res && mis;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and compare every meaningful output against the model.
  task automatic apply(input bit rst, input bit ev, input logic [ESW-1:0] eb, input bit ws,
                       input bit dok, input logic [DW-1:0] rd);
    bit load;
    logic [DW-1:0] raw;
    reset = rst; es_valid = ev; es_bus = eb; ws_allowin = ws; data_ok = dok; rdata = rd;
    #1;
    e_ale     = m_valid && ale_of(m_op, m_res, m_alu);
    load      = m_valid && m_res && !e_ale;
    e_live    = dok && load && !m_have;
    e_ready   = !load || m_have || e_live;
    e_valid   = m_valid && e_ready;
    e_allowin = !m_valid || (e_ready && ws);
    raw       = m_have ? m_data : rd;
    e_result  = m_res ? extract(m_op, m_alu, raw) : m_alu;
    chk("ms_allowin", ms_allowin, e_allowin);
    chk("ms_to_ws_valid", ms_valid_o, e_valid);
    chk("fwd_we", fwd_bus[DW+RW+1], m_valid && m_we && !e_ale);
    chk("fwd_ready", fwd_bus[DW+RW], e_ready);
    if (m_valid) chk("fwd_dest", fwd_bus[DW +: RW], m_dest);
    if (m_valid && e_ready) chk("fwd_result", fwd_bus[DW-1:0], e_result);
    if (e_valid) begin
      chk("ws_pc", ms_bus[PW-1:0], m_pc);
      chk("ws_result", ms_bus[PW +: DW], e_result);
      chk("ws_dest", ms_bus[PW+DW +: RW], m_dest);
      chk("ws_gr_we", ms_bus[PW+DW+RW], m_we && !e_ale);
`ifdef MEM_ALIGN_CHK_EN
      chk("ws_ale", ms_bus[PW+DW+RW+1], e_ale);
`endif
    end
  endtask

  task automatic advance();
    if (reset) begin
      m_valid = 1'b0;
      m_have  = 1'b0;
    end else if (e_live && !ws_allowin) begin
      m_have = 1'b1;
      m_data = rdata;
    end else if (e_allowin) begin
      m_valid = es_valid;
      m_have  = 1'b0;
      if (es_valid) begin
        m_op   = es_bus[ESW-1 -: 3];
        m_res  = es_bus[ESW-4];
        m_we   = es_bus[ESW-5];
        m_dest = es_bus[PW+DW +: RW];
        m_alu  = es_bus[PW +: DW];
        m_pc   = es_bus[PW-1:0];
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [ESW-1:0] NOP = '0;

  initial begin
    reset = 1'b1; es_valid = 1'b0; es_bus = '0; ws_allowin = 1'b1; data_ok = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    apply(0, 0, NOP, 1, 0, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_valid", ms_valid_o, 0);
    chk("rst_fwd_we", fwd_bus[DW+RW+1], 0);
    advance();

    // ALU op passes straight through
    apply(0, 1, mk(0, 0, 1, 5, 32'h1234, 32'h100), 1, 0, 0);
    advance();
    apply(0, 0, NOP, 1, 0, 0);
    chk("alu_valid", ms_valid_o, 1);
    chk("alu_result", ms_bus[PW +: DW], 32'h1234);
    chk("alu_fwd_we", fwd_bus[DW+RW+1], 1);
    chk("alu_fwd_ready", fwd_bus[DW+RW], 1);
    advance();

    // LB at byte 3, data returns after three wait cycles
    apply(0, 1, mk(1, 1, 1, 7, 32'h1003, 32'h104), 1, 0, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, NOP, 1, 0, 32'h80FF_00AA);
      chk("lb_wait_valid", ms_valid_o, 0);
      chk("lb_wait_ready", fwd_bus[DW+RW], 0);
      advance();
    end
    apply(0, 0, NOP, 1, 1, 32'h80FF_00AA);
    chk("lb_valid", ms_valid_o, 1);
    chk("lb_result", ms_bus[PW +: DW], 32'hFFFF_FF80);
    advance();

    // LHU returned while writeback stalls; result must survive the SRAM data changing
    apply(0, 1, mk(4, 1, 1, 9, 32'h2002, 32'h108), 1, 0, 0);
    advance();
    apply(0, 0, NOP, 0, 1, 32'h9ABC_1234);
    chk("lhu_ok_result", ms_bus[PW +: DW], 32'h0000_9ABC);
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, NOP, 0, 0, $urandom);
      chk("lhu_hold_valid", ms_valid_o, 1);
      chk("lhu_hold_result", ms_bus[PW +: DW], 32'h0000_9ABC);
      chk("lhu_hold_allowin", ms_allowin, 0);
      advance();
    end
    apply(0, 0, NOP, 1, 0, 32'h5555_5555);
    chk("lhu_retire_allowin", ms_allowin, 1);
    chk("lhu_retire_result", ms_bus[PW +: DW], 32'h0000_9ABC);
    advance();

    // Back-to-back LW with single-cycle data_ok
    apply(0, 1, mk(0, 1, 1, 1, 32'h40, 32'h10C), 1, 0, 0);
    advance();
    apply(0, 1, mk(0, 1, 1, 2, 32'h44, 32'h110), 1, 1, 32'h1111_2222);
    chk("b2b_1_valid", ms_valid_o, 1);
    chk("b2b_1_result", ms_bus[PW +: DW], 32'h1111_2222);
    chk("b2b_1_allowin", ms_allowin, 1);
    advance();
    apply(0, 0, NOP, 1, 1, 32'h3333_4444);
    chk("b2b_2_valid", ms_valid_o, 1);
    chk("b2b_2_result", ms_bus[PW +: DW], 32'h3333_4444);
    advance();

    // Reset while waiting; a late data_ok must be ignored
    apply(0, 1, mk(0, 1, 1, 3, 32'h100, 32'h114), 1, 0, 0);
    advance();
    apply(1, 0, NOP, 1, 0, 0);
    advance();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, NOP, 1, 1, 32'hDEAD_BEEF);
      chk("rstwait_valid", ms_valid_o, 0);
      chk("rstwait_allowin", ms_allowin, 1);
      advance();
    end

    // Misaligned LW
    apply(0, 1, mk(0, 1, 1, 4, 32'h1002, 32'h118), 1, 0, 0);
    advance();
    apply(0, 0, NOP, 1, 0, 0);
`ifdef MEM_ALIGN_CHK_EN
    chk("ale_valid", ms_valid_o, 1);
    chk("ale_bit", ms_bus[PW+DW+RW+1], 1);
    chk("ale_gr_we", ms_bus[PW+DW+RW], 0);
    advance();
`else
    chk("mis_wait_valid", ms_valid_o, 0);
    advance();
    apply(0, 0, NOP, 1, 1, 32'hCAFE_F00D);
    chk("mis_lw_result", ms_bus[PW +: DW], 32'hCAFE_F00D);
    advance();
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 7,
            mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 31), $urandom, $urandom),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4,
            $urandom);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
